// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// The stall feature enabled by MEM_RESP_STALL_EN uses MEM_LFSR_SEED and lfsr_next.
package mem_responder_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    // Reset value of the stall LFSR
    localparam logic [7:0] MEM_LFSR_SEED = 8'hA5;

    // Latency counter width: holds up to LATENCY-1 (14) plus a stall of 3
    localparam int CNT_W = 5;

    // One step of the 8-bit Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word-wide memory with per-byte write enables.
// Read and write are both synchronous; one access per enabled edge.
module mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Enabled edge: either merge the enabled byte lanes or register the word
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time, services it from
// mem_array after a fixed latency and returns a one-cycle mem_resp pulse.
// Optional macro MEM_RESP_STALL_EN adds an LFSR-driven 0..3 cycle stall per request.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        protocol_err
);

    mem_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_be;
    logic                  cap_write;

    logic                  req;
    logic                  in_idle;
    logic [CNT_W-1:0]      extra;
    logic [CNT_W-1:0]      load_val;
    logic                  enter_resp;

    logic                  arr_we;
    logic [3:0]            arr_be;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [31:0]           arr_wdata;
    logic [31:0]           arr_rdata;

    // Byte-offset and alias bits of the address take no part in the access
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

    assign req     = mem_read | mem_write;
    assign in_idle = (state == MEM_IDLE);

`ifdef MEM_RESP_STALL_EN
    logic [7:0] lfsr;

    // Advance the stall LFSR once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= MEM_LFSR_SEED;
        end else if (in_idle && req) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Stall is taken from the value before this request's advance
    assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
    assign extra = '0;
`endif

    // Counter value loaded at acceptance; zero means go straight to RESP
    assign load_val = CNT_W'(LATENCY - 1) + extra;

    // The array access happens on the edge that enters RESP
    assign enter_resp = (in_idle && req && (load_val == '0)) ||
                        ((state == MEM_WAIT) && (cnt == CNT_W'(1)));

    // In IDLE the access can only be the zero-wait case, so use live inputs
    assign arr_we    = in_idle ? mem_write : cap_write;
    assign arr_be    = in_idle ? mem_byte_enable : cap_be;
    assign arr_addr  = in_idle ? mem_address[ADDR_WIDTH+1:2] : cap_addr;
    assign arr_wdata = in_idle ? mem_wdata : cap_wdata;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Response outputs come straight from registers; read data is zero outside RESP
    assign mem_resp  = (state == MEM_RESP);
    assign mem_rdata = (mem_resp && !cap_write) ? arr_rdata : 32'h0;

    // Request FSM with capture registers and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= MEM_IDLE;
            cnt          <= '0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_be       <= '0;
            cap_write    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (req) begin
                        cap_addr  <= mem_address[ADDR_WIDTH+1:2];
                        cap_wdata <= mem_wdata;
                        cap_be    <= mem_byte_enable;
                        cap_write <= mem_write;
                        cnt       <= load_val;
                        if (mem_read && mem_write) begin
                            protocol_err <= 1'b1;
                        end
                        state <= (load_val == '0) ? MEM_RESP : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= MEM_RESP;
                    end
                end
                MEM_RESP: begin
                    state <= MEM_IDLE;
                end
                default: begin
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a word-array model.
module tb_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        protocol_err;

    mem_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .protocol_err    (protocol_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model[int];
    int          written_q[$];
    logic [7:0]  stall_lfsr;

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) & ((32'd1 << AW) - 1));
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected latency of the next accepted request; advances the stall model
    task automatic check_lat(input string tag, input int lat);
        int exp;
        exp = LAT;
`ifdef MEM_RESP_STALL_EN
        exp = LAT + int'(stall_lfsr[1:0]);
        stall_lfsr = {stall_lfsr[6:0], stall_lfsr[7] ^ stall_lfsr[5] ^ stall_lfsr[4] ^ stall_lfsr[3]};
`endif
        checks++;
        assert (lat == exp) else begin
            failures++;
            $error("FAIL %s latency observed=%0d expected=%0d", tag, lat, exp);
        end
    endtask

    // Issue one request, scramble inputs while waiting, return data and latency
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit drop,
                          output logic [31:0] rdata, output int lat);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        lat   = 0;
        rdata = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_resp === 1'b1) begin
                lat   = i;
                rdata = mem_rdata;
                break;
            end
            mem_address     = $urandom();
            mem_wdata       = $urandom();
            mem_byte_enable = 4'($urandom_range(0, 15));
            if (drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check1("resp_one_cycle", mem_resp, 1'b0);
        check32("rdata_cleared", mem_rdata, 32'h0);
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int idx;
        logic [31:0] word;
        idx  = word_idx(addr);
        word = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) word[b*8 +: 8] = data[b*8 +: 8];
        end
        if (!model.exists(idx)) written_q.push_back(idx);
        model[idx] = word;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] rdata;
        int lat;
        do_req(1'b0, 1'b1, addr, data, be, 1'b0, rdata, lat);
        check_lat("write_latency", lat);
        model_write(addr, data, be);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input bit drop);
        logic [31:0] rdata;
        int lat;
        exp_q.push_back(model[word_idx(addr)]);
        do_req(1'b1, 1'b0, addr, 32'h0, 4'h0, drop, rdata, lat);
        check_lat("read_latency", lat);
        check32(tag, rdata, exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] rdata;
        int lat;
        int idx;
        logic [31:0] addr;
        logic [3:0]  be;

        // Reset
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address = 32'h0;
        mem_wdata = 32'h0;
        stall_lfsr = 8'hA5;
        repeat (3) @(negedge clk);
        check1("reset_resp", mem_resp, 1'b0);
        check32("reset_rdata", mem_rdata, 32'h0);
        check1("reset_perr", protocol_err, 1'b0);
        rst_n = 1'b1;

        // Write then read back
        do_write(32'h100, 32'hDEADBEEF, 4'hF);
        do_read("rd_deadbeef", 32'h100, 1'b0);

        // Byte lanes
        do_write(32'h104, 32'h11223344, 4'hF);
        do_write(32'h104, 32'hAABBCCDD, 4'b0101);
        do_read("rd_byte_lanes", 32'h104, 1'b0);
        check32("byte_lane_model", model[word_idx(32'h104)], 32'h11BB33DD);

        // Zero byte enables leave the word intact
        do_write(32'h100, 32'h0, 4'h0);
        do_read("rd_be_zero", 32'h100, 1'b0);

        // Aliasing through upper and low address bits
        do_read("rd_alias_hi", 32'h100 + (32'd1 << (AW + 2)), 1'b0);
        do_read("rd_alias_lo", 32'h103, 1'b0);

        // Request dropped during WAIT still completes
        do_read("rd_dropped", 32'h104, 1'b1);

`ifndef MEM_RESP_STALL_EN
        // Held read: one pulse, then one idle cycle, then LAT cycles again
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h100;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            check1("held_resp", mem_resp, (n >= LAT) && (((n - LAT) % (LAT + 1)) == 0));
            if (mem_resp === 1'b1) check32("held_rdata", mem_rdata, 32'hDEADBEEF);
        end
        mem_read = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check1("held_release", mem_resp, 1'b0);
        end
`endif

        // Simultaneous read and write acts as a write and flags an error
        do_req(1'b1, 1'b1, 32'h0, 32'h5, 4'hF, 1'b0, rdata, lat);
        check_lat("rw_latency", lat);
        model_write(32'h0, 32'h5, 4'hF);
        check1("perr_set", protocol_err, 1'b1);
        do_read("rd_after_rw", 32'h0, 1'b0);
        check1("perr_sticky", protocol_err, 1'b1);

        // Randomized traffic over aliased addresses
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                idx  = $urandom_range(0, (1 << AW) - 1);
                addr = ($urandom() & ~32'hFFC) | (32'(idx) << 2);
                be   = model.exists(idx) ? 4'($urandom_range(0, 15)) : 4'hF;
                do_write(addr, $urandom(), be);
            end else begin
                idx  = written_q[$urandom_range(0, written_q.size() - 1)];
                addr = ($urandom() & ~32'hFFC) | (32'(idx) << 2);
                do_read("rd_random", addr, 1'b0);
            end
        end

        // Reset during WAIT discards the pending write
        do_write(32'h8, 32'h0, 4'hF);
        @(negedge clk);
        mem_write       = 1'b1;
        mem_address     = 32'h8;
        mem_wdata       = 32'hFFFFFFFF;
        mem_byte_enable = 4'hF;
        @(negedge clk);
        rst_n      = 1'b0;
        mem_write  = 1'b0;
        stall_lfsr = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            check1("reset_mid_resp", mem_resp, 1'b0);
        end
        check1("reset_mid_perr", protocol_err, 1'b0);
        rst_n = 1'b1;
        do_read("rd_after_reset", 32'h8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
